// File: rtl/bp_me_mem_link_client_ooo.sv
// Tagged out-of-order memory link client: commands allocate a return-route slot whose index
// is the memory tag; responses are routed back by tag and free their slot.
module bp_me_mem_link_client_ooo #(
  parameter int unsigned hdr_width_p       = 32,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned cord_width_p      = 8,
  parameter int unsigned cid_width_p       = 2,
  parameter int unsigned num_outstanding_p = 4,
  localparam int unsigned tag_width_lp     = $clog2(num_outstanding_p),
  localparam int unsigned cnt_width_lp     = $clog2(num_outstanding_p + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,

  input  logic [hdr_width_p-1:0]               cmd_hdr_i,
  input  logic [data_width_p-1:0]              cmd_data_i,
  input  logic [cord_width_p-1:0]              cmd_src_cord_i,
  input  logic [cid_width_p-1:0]               cmd_src_cid_i,
  input  logic                                 cmd_v_i,
  output logic                                 cmd_yumi_o,

  output logic [hdr_width_p+data_width_p-1:0]  mem_cmd_o,
  output logic [tag_width_lp-1:0]              mem_cmd_tag_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_yumi_i,

  input  logic [hdr_width_p+data_width_p-1:0]  mem_resp_i,
  input  logic [tag_width_lp-1:0]              mem_resp_tag_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_ready_o,

  output logic [hdr_width_p-1:0]               resp_hdr_o,
  output logic [data_width_p-1:0]              resp_data_o,
  output logic [cord_width_p-1:0]              resp_dst_cord_o,
  output logic [cid_width_p-1:0]               resp_dst_cid_o,
  output logic                                 resp_v_o,
  input  logic                                 resp_ready_i,

  output logic [cnt_width_lp-1:0]              outstanding_o,
  output logic                                 tag_err_o
);

  logic [num_outstanding_p-1:0] valid_q, valid_d;
  logic [cord_width_p-1:0]      cord_q [num_outstanding_p];
  logic [cord_width_p-1:0]      cord_d [num_outstanding_p];
  logic [cid_width_p-1:0]       cid_q  [num_outstanding_p];
  logic [cid_width_p-1:0]       cid_d  [num_outstanding_p];
  logic [cnt_width_lp-1:0]      count_q, count_d;
  logic                         err_q, err_d;

  logic [tag_width_lp-1:0]      free_idx;
  logic                         found;
  logic                         full;
  logic                         hit;
  logic                         alloc;
  logic                         free;

  // Lowest free slot, taken from registered state only so a slot freed this cycle is not reused
  // until the next one.
  always_comb begin
    free_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < num_outstanding_p; i++) begin
      if (!found && !valid_q[i]) begin
        free_idx = tag_width_lp'(i);
        found    = 1'b1;
      end
    end
  end

  assign full  = &valid_q;
  assign hit   = valid_q[mem_resp_tag_i];
  assign alloc = reset_n_i & cmd_v_i & ~full & mem_cmd_yumi_i;
  assign free  = reset_n_i & mem_resp_v_i & hit & resp_ready_i;

  assign mem_cmd_o        = {cmd_data_i, cmd_hdr_i};
  assign mem_cmd_tag_o    = free_idx;
  assign mem_cmd_v_o      = reset_n_i & cmd_v_i & ~full;
  assign cmd_yumi_o       = alloc;

  assign resp_hdr_o       = mem_resp_i[hdr_width_p-1:0];
  assign resp_data_o      = mem_resp_i[hdr_width_p+data_width_p-1:hdr_width_p];
  assign resp_dst_cord_o  = cord_q[mem_resp_tag_i];
  assign resp_dst_cid_o   = cid_q[mem_resp_tag_i];
  assign resp_v_o         = reset_n_i & mem_resp_v_i & hit;
  // Responses on unallocated tags are always accepted so a stray tag cannot wedge memory.
  assign mem_resp_ready_o = reset_n_i & (hit ? resp_ready_i : 1'b1);

  assign outstanding_o    = count_q;
  assign tag_err_o        = err_q;

  always_comb begin
    valid_d = valid_q;
    cord_d  = cord_q;
    cid_d   = cid_q;
    if (alloc) begin
      valid_d[free_idx] = 1'b1;
      cord_d[free_idx]  = cmd_src_cord_i;
      cid_d[free_idx]   = cmd_src_cid_i;
    end
    if (free) begin
      valid_d[mem_resp_tag_i] = 1'b0;
    end
    count_d = count_q + cnt_width_lp'(alloc) - cnt_width_lp'(free);
    err_d   = err_q | (reset_n_i & mem_resp_v_i & ~hit);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < num_outstanding_p; i++) begin
        cord_q[i] <= '0;
        cid_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < num_outstanding_p; i++) begin
        cord_q[i] <= cord_d[i];
        cid_q[i]  <= cid_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bp_me_mem_link_client_ooo.sv
// Directed bench for bp_me_mem_link_client_ooo: allocation, out-of-order return, full stall,
// backpressure, bad tags and mid-traffic reset.
module tb_bp_me_mem_link_client_ooo;

  localparam int unsigned HDR  = 8;
  localparam int unsigned DATA = 16;
  localparam int unsigned CORD = 4;
  localparam int unsigned CID  = 2;
  localparam int unsigned N    = 4;
  localparam int unsigned TAG  = 2;
  localparam int unsigned CNT  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [HDR-1:0]       cmd_hdr;
  logic [DATA-1:0]      cmd_data;
  logic [CORD-1:0]      cmd_cord;
  logic [CID-1:0]       cmd_cid;
  logic                 cmd_v;
  logic                 cmd_yumi;
  logic [HDR+DATA-1:0]  mem_cmd;
  logic [TAG-1:0]       mem_cmd_tag;
  logic                 mem_cmd_v;
  logic                 mem_cmd_yumi;
  logic [HDR+DATA-1:0]  mem_resp;
  logic [TAG-1:0]       mem_resp_tag;
  logic                 mem_resp_v;
  logic                 mem_resp_ready;
  logic [HDR-1:0]       resp_hdr;
  logic [DATA-1:0]      resp_data;
  logic [CORD-1:0]      resp_cord;
  logic [CID-1:0]       resp_cid;
  logic                 resp_v;
  logic                 resp_ready;
  logic [CNT-1:0]       outstanding;
  logic                 tag_err;

  int checks   = 0;
  int failures = 0;

  bp_me_mem_link_client_ooo #(
    .hdr_width_p       (HDR),
    .data_width_p      (DATA),
    .cord_width_p      (CORD),
    .cid_width_p       (CID),
    .num_outstanding_p (N)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .cmd_hdr_i        (cmd_hdr),
    .cmd_data_i       (cmd_data),
    .cmd_src_cord_i   (cmd_cord),
    .cmd_src_cid_i    (cmd_cid),
    .cmd_v_i          (cmd_v),
    .cmd_yumi_o       (cmd_yumi),
    .mem_cmd_o        (mem_cmd),
    .mem_cmd_tag_o    (mem_cmd_tag),
    .mem_cmd_v_o      (mem_cmd_v),
    .mem_cmd_yumi_i   (mem_cmd_yumi),
    .mem_resp_i       (mem_resp),
    .mem_resp_tag_i   (mem_resp_tag),
    .mem_resp_v_i     (mem_resp_v),
    .mem_resp_ready_o (mem_resp_ready),
    .resp_hdr_o       (resp_hdr),
    .resp_data_o      (resp_data),
    .resp_dst_cord_o  (resp_cord),
    .resp_dst_cid_o   (resp_cid),
    .resp_v_o         (resp_v),
    .resp_ready_i     (resp_ready),
    .outstanding_o    (outstanding),
    .tag_err_o        (tag_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_v        = 1'b0;
    mem_cmd_yumi = 1'b0;
    mem_resp_v   = 1'b0;
    resp_ready   = 1'b0;
  endtask

  // Present a command that memory accepts this cycle; expect the given tag.
  task automatic do_cmd(input logic [CORD-1:0] cord, input logic [CID-1:0] cid,
                        input logic [TAG-1:0] exp_tag, input string name);
    cmd_v        = 1'b1;
    cmd_cord     = cord;
    cmd_cid      = cid;
    cmd_hdr      = {4'h0, cord};
    cmd_data     = {12'h000, cord};
    mem_cmd_yumi = 1'b1;
    #1;
    check({name, "_v"},   32'(mem_cmd_v), 32'd1);
    check({name, "_tag"}, 32'(mem_cmd_tag), 32'(exp_tag));
    tick();
    idle();
  endtask

  // Present a response with the adapter ready; expect routing to cord/cid.
  task automatic do_resp(input logic [TAG-1:0] tag, input logic [CORD-1:0] exp_cord,
                         input logic [CID-1:0] exp_cid, input string name);
    mem_resp_v   = 1'b1;
    mem_resp_tag = tag;
    mem_resp     = {16'h1234, 8'h00};
    resp_ready   = 1'b1;
    #1;
    check({name, "_v"},    32'(resp_v), 32'd1);
    check({name, "_cord"}, 32'(resp_cord), 32'(exp_cord));
    check({name, "_cid"},  32'(resp_cid), 32'(exp_cid));
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    idle();
    cmd_hdr      = '0;
    cmd_data     = '0;
    cmd_cord     = '0;
    cmd_cid      = '0;
    mem_resp     = '0;
    mem_resp_tag = '0;

    // Outputs held low in reset even with live inputs.
    cmd_v        = 1'b1;
    mem_resp_v   = 1'b1;
    mem_cmd_yumi = 1'b1;
    resp_ready   = 1'b1;
    #2;
    check("rst_mem_cmd_v",   32'(mem_cmd_v), 32'd0);
    check("rst_cmd_yumi",    32'(cmd_yumi), 32'd0);
    check("rst_resp_v",      32'(resp_v), 32'd0);
    check("rst_resp_ready",  32'(mem_resp_ready), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_tag_err",     32'(tag_err), 32'd0);
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // 1: single command round trip.
    cmd_v        = 1'b1;
    cmd_cord     = 4'd3;
    cmd_cid      = 2'd1;
    cmd_hdr      = 8'hA5;
    cmd_data     = 16'hC0DE;
    mem_cmd_yumi = 1'b1;
    #1;
    check("t1_cmd_v",    32'(mem_cmd_v), 32'd1);
    check("t1_cmd_tag",  32'(mem_cmd_tag), 32'd0);
    check("t1_cmd_yumi", 32'(cmd_yumi), 32'd1);
    check("t1_mem_cmd",  32'(mem_cmd), 32'h00C0DEA5);
    tick();
    idle();
    check("t1_out1", 32'(outstanding), 32'd1);
    mem_resp_v   = 1'b1;
    mem_resp_tag = 2'd0;
    mem_resp     = {16'hBEEF, 8'h5A};
    resp_ready   = 1'b1;
    #1;
    check("t1_resp_v",     32'(resp_v), 32'd1);
    check("t1_resp_cord",  32'(resp_cord), 32'd3);
    check("t1_resp_cid",   32'(resp_cid), 32'd1);
    check("t1_resp_hdr",   32'(resp_hdr), 32'h5A);
    check("t1_resp_data",  32'(resp_data), 32'hBEEF);
    check("t1_resp_ready", 32'(mem_resp_ready), 32'd1);
    tick();
    idle();
    check("t1_out0", 32'(outstanding), 32'd0);

    // 2: fill all four slots, fifth command stalls.
    do_cmd(4'd1, 2'd0, 2'd0, "t2_c0");
    do_cmd(4'd2, 2'd1, 2'd1, "t2_c1");
    do_cmd(4'd3, 2'd2, 2'd2, "t2_c2");
    do_cmd(4'd4, 2'd3, 2'd3, "t2_c3");
    check("t2_out4", 32'(outstanding), 32'd4);
    cmd_v = 1'b1;
    #1;
    check("t2_full_v",    32'(mem_cmd_v), 32'd0);
    check("t2_full_yumi", 32'(cmd_yumi), 32'd0);
    tick();
    check("t2_full_v2",   32'(mem_cmd_v), 32'd0);
    idle();

    // 3: out-of-order return.
    do_resp(2'd2, 4'd3, 2'd2, "t3_r2");
    check("t3_out3", 32'(outstanding), 32'd3);
    do_resp(2'd0, 4'd1, 2'd0, "t3_r0");
    do_resp(2'd3, 4'd4, 2'd3, "t3_r3");
    do_resp(2'd1, 4'd2, 2'd1, "t3_r1");
    check("t3_out0", 32'(outstanding), 32'd0);
    do_cmd(4'd7, 2'd3, 2'd0, "t3_next");

    // 4: full table, command and freeing response in the same cycle.
    do_cmd(4'd8, 2'd0, 2'd1, "t4_c1");
    do_cmd(4'd9, 2'd1, 2'd2, "t4_c2");
    do_cmd(4'd10, 2'd2, 2'd3, "t4_c3");
    check("t4_out4", 32'(outstanding), 32'd4);
    cmd_v        = 1'b1;
    cmd_cord     = 4'd11;
    cmd_cid      = 2'd3;
    mem_resp_v   = 1'b1;
    mem_resp_tag = 2'd1;
    resp_ready   = 1'b1;
    #1;
    check("t4_stall_v",  32'(mem_cmd_v), 32'd0);
    check("t4_resp_v",   32'(resp_v), 32'd1);
    check("t4_resp_cord", 32'(resp_cord), 32'd8);
    tick();
    mem_resp_v   = 1'b0;
    resp_ready   = 1'b0;
    mem_cmd_yumi = 1'b1;
    #1;
    check("t4_retry_v",   32'(mem_cmd_v), 32'd1);
    check("t4_retry_tag", 32'(mem_cmd_tag), 32'd1);
    tick();
    idle();
    check("t4_out4b", 32'(outstanding), 32'd4);

    // Not full: alloc and free in one cycle, net count unchanged, freed slot unseen that cycle.
    do_resp(2'd2, 4'd9, 2'd1, "t4_r2");
    check("t4_out3", 32'(outstanding), 32'd3);
    cmd_v        = 1'b1;
    cmd_cord     = 4'd12;
    cmd_cid      = 2'd0;
    mem_cmd_yumi = 1'b1;
    mem_resp_v   = 1'b1;
    mem_resp_tag = 2'd3;
    resp_ready   = 1'b1;
    #1;
    check("t4_both_tag", 32'(mem_cmd_tag), 32'd2);
    check("t4_both_rv",  32'(resp_v), 32'd1);
    tick();
    idle();
    check("t4_both_out", 32'(outstanding), 32'd3);
    cmd_v = 1'b1;
    #1;
    check("t4_free3_tag", 32'(mem_cmd_tag), 32'd3);
    idle();

    // 5: adapter backpressure on a valid hit (slots 0,1,2 live).
    mem_resp_v   = 1'b1;
    mem_resp_tag = 2'd0;
    resp_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_hold_v",     32'(resp_v), 32'd1);
      check("t5_hold_ready", 32'(mem_resp_ready), 32'd0);
      tick();
      check("t5_hold_out",   32'(outstanding), 32'd3);
    end
    resp_ready = 1'b1;
    #1;
    check("t5_rel_ready", 32'(mem_resp_ready), 32'd1);
    check("t5_rel_cord",  32'(resp_cord), 32'd7);
    tick();
    idle();
    check("t5_out2", 32'(outstanding), 32'd2);

    // 6: response on empty slot 3, then async reset mid-traffic.
    mem_resp_v   = 1'b1;
    mem_resp_tag = 2'd3;
    resp_ready   = 1'b0;
    #1;
    check("t6_bad_ready", 32'(mem_resp_ready), 32'd1);
    check("t6_bad_v",     32'(resp_v), 32'd0);
    tick();
    idle();
    check("t6_err",        32'(tag_err), 32'd1);
    tick();
    check("t6_err_sticky", 32'(tag_err), 32'd1);
    check("t6_out2",       32'(outstanding), 32'd2);
    cmd_v        = 1'b1;
    mem_cmd_yumi = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_v",   32'(mem_cmd_v), 32'd0);
    check("t6_rst_out", 32'(outstanding), 32'd0);
    check("t6_rst_err", 32'(tag_err), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    #1;
    mem_resp_v   = 1'b1;
    mem_resp_tag = 2'd1;
    resp_ready   = 1'b1;
    #1;
    check("t6_post_v",     32'(resp_v), 32'd0);
    check("t6_post_ready", 32'(mem_resp_ready), 32'd1);
    tick();
    idle();
    check("t6_post_err", 32'(tag_err), 32'd1);
    check("t6_post_out", 32'(outstanding), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
